store_buffer: RTL and testbench

Posted-write buffer between the core's load/store unit and data memory. Stores issued in the memory stage are queued in a small FIFO and written to memory in later cycles when the port is idle; loads always get the memory port immediately. Pending store bytes matching a load address are forwarded into the load result, so the core never observes stale data. Full-buffer back-pressure is exported as a stall request to the hazard logic.

---
 rtl/store_buffer.sv | 143 ++++++++++++++
 tb/tb_store_buffer.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/store_buffer.sv
// Posted-write store buffer: queues LSU stores, drains them when the memory port is idle,
// and forwards pending store bytes into loads. Optional store merging: SB_COALESCE_EN.
module store_buffer #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned AW    = 32,
    parameter int unsigned DW    = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cs,
    input  logic          wr,
    input  logic [3:0]    mask,
    input  logic [AW-1:0] addr,
    input  logic [DW-1:0] data_wr,
    output logic [DW-1:0] data_rd,
    output logic          stall_store,
    output logic          sb_empty,
    output logic          mem_cs,
    output logic          mem_wr,
    output logic [3:0]    mem_mask,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_data_wr,
    input  logic [DW-1:0] mem_data_rd,
    input  logic          mem_ready
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH + 1);

    logic [PW-1:0] head_q, tail_q;
    logic [CW-1:0] count_q, count_d;
    logic          valid_q [DEPTH];
    logic [AW-3:0] word_q  [DEPTH];
    logic [3:0]    mask_q  [DEPTH];
    logic [DW-1:0] data_q  [DEPTH];

    logic          load, full, drain, drain_done, enq, merge;
    logic [PW-1:0] fwd_idx;

    assign load       = cs && !wr;
    assign full       = (count_q == CW'(DEPTH));
    assign sb_empty   = (count_q == '0);
    assign drain      = !sb_empty && !load;
    assign drain_done = drain && mem_ready;

`ifdef SB_COALESCE_EN
    logic [PW-1:0] young;
    logic [DW-1:0] merged_data;

    assign young = tail_q - PW'(1);
    // Merging into the head is unsafe while that head is retiring at this edge.
    assign merge = cs && wr && !sb_empty && valid_q[young] &&
                   (word_q[young] == addr[AW-1:2]) && !(young == head_q && drain_done);

    always_comb begin
        merged_data = data_q[young];
        for (int b = 0; b < 4; b++) begin
            if (mask[b]) merged_data[8*b +: 8] = data_wr[8*b +: 8];
        end
    end
`else
    assign merge = 1'b0;
`endif

    assign stall_store = full && !merge;
    assign enq         = cs && wr && !full && !merge;

    always_comb begin
        count_d = count_q;
        case ({enq, drain_done})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // Walk oldest to youngest so the youngest matching byte wins.
    always_comb begin
        data_rd = mem_data_rd;
        fwd_idx = head_q;
        for (int i = 0; i < DEPTH; i++) begin
            fwd_idx = head_q + PW'(i);
            if (valid_q[fwd_idx] && word_q[fwd_idx] == addr[AW-1:2]) begin
                for (int b = 0; b < 4; b++) begin
                    if (mask_q[fwd_idx][b]) data_rd[8*b +: 8] = data_q[fwd_idx][8*b +: 8];
                end
            end
        end
    end

    always_comb begin
        mem_cs      = 1'b0;
        mem_wr      = 1'b0;
        mem_mask    = 4'h0;
        mem_addr    = '0;
        mem_data_wr = '0;
        if (load) begin
            mem_cs   = 1'b1;
            mem_addr = addr;
            mem_mask = mask;
        end else if (drain) begin
            mem_cs      = 1'b1;
            mem_wr      = 1'b1;
            mem_addr    = {word_q[head_q], 2'b00};
            mem_mask    = mask_q[head_q];
            mem_data_wr = data_q[head_q];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                valid_q[i] <= 1'b0;
                word_q[i]  <= '0;
                mask_q[i]  <= 4'h0;
                data_q[i]  <= '0;
            end
        end else begin
            if (drain_done) begin
                valid_q[head_q] <= 1'b0;
                head_q          <= head_q + PW'(1);
            end
            if (enq) begin
                valid_q[tail_q] <= 1'b1;
                word_q[tail_q]  <= addr[AW-1:2];
                mask_q[tail_q]  <= mask;
                data_q[tail_q]  <= data_wr;
                tail_q          <= tail_q + PW'(1);
            end
`ifdef SB_COALESCE_EN
            if (merge) begin
                mask_q[young] <= mask_q[young] | mask;
                data_q[young] <= merged_data;
            end
`endif
            count_q <= count_d;
        end
    end

endmodule

// File: tb/tb_store_buffer.sv
// Directed self-checking bench for store_buffer; also covers the SB_COALESCE_EN build.
module tb_store_buffer;

    logic        clk = 1'b0;
    logic        rst;
    logic        cs, wr;
    logic [3:0]  mask;
    logic [31:0] addr, data_wr, data_rd;
    logic        stall_store, sb_empty;
    logic        mem_cs, mem_wr;
    logic [3:0]  mem_mask;
    logic [31:0] mem_addr, mem_data_wr, mem_data_rd;
    logic        mem_ready;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    store_buffer #(.DEPTH(4), .AW(32), .DW(32)) dut (
        .clk        (clk),
        .rst        (rst),
        .cs         (cs),
        .wr         (wr),
        .mask       (mask),
        .addr       (addr),
        .data_wr    (data_wr),
        .data_rd    (data_rd),
        .stall_store(stall_store),
        .sb_empty   (sb_empty),
        .mem_cs     (mem_cs),
        .mem_wr     (mem_wr),
        .mem_mask   (mem_mask),
        .mem_addr   (mem_addr),
        .mem_data_wr(mem_data_wr),
        .mem_data_rd(mem_data_rd),
        .mem_ready  (mem_ready)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance one edge; inputs change and outputs settle 1 time unit later.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic store(input logic [31:0] a, input logic [3:0] m, input logic [31:0] d);
        cs = 1'b1; wr = 1'b1; addr = a; mask = m; data_wr = d;
        #1;
    endtask

    task automatic idle();
        cs = 1'b0; wr = 1'b0; addr = '0; mask = 4'h0; data_wr = '0;
        #1;
    endtask

    initial begin
        rst = 1'b1; cs = 1'b0; wr = 1'b0; mask = 4'h0; addr = '0; data_wr = '0;
        mem_data_rd = 32'h12345678; mem_ready = 1'b1;
        step(); step();
        chk("reset_empty", 32'(sb_empty), 32'd1);
        chk("reset_stall", 32'(stall_store), 32'd0);
        chk("reset_memcs", 32'(mem_cs), 32'd0);
        chk("reset_fwd", data_rd, 32'h12345678);
        rst = 1'b0;
        step();

        // Single word store drains on the following edge.
        store(32'h100, 4'hF, 32'hDEADBEEF);
        chk("t1_idle_memcs", 32'(mem_cs), 32'd0);
        step(); idle();
        chk("t1_pending", 32'(sb_empty), 32'd0);
        chk("t1_memwr", 32'(mem_wr), 32'd1);
        chk("t1_addr", mem_addr, 32'h100);
        chk("t1_mask", 32'(mem_mask), 32'hF);
        chk("t1_data", mem_data_wr, 32'hDEADBEEF);
        step();
        chk("t1_empty", 32'(sb_empty), 32'd1);

        // Byte store forwarded into an immediate load; load blocks the drain.
        store(32'h101, 4'b0010, 32'h0000AA00);
        step();
        cs = 1'b1; wr = 1'b0; addr = 32'h100; mask = 4'hF; mem_data_rd = 32'h11223344;
        #1;
        chk("t2_fwd", data_rd, 32'h1122AA44);
        chk("t2_load_wr", 32'(mem_wr), 32'd0);
        chk("t2_load_addr", mem_addr, 32'h100);
        step(); idle();
        chk("t2_not_drained", 32'(sb_empty), 32'd0);
        chk("t2_drain_mask", 32'(mem_mask), 32'h2);
        chk("t2_drain_data", mem_data_wr, 32'h0000AA00);
        step();
        chk("t2_empty", 32'(sb_empty), 32'd1);

        // Fill with memory stalled, hold the fifth store, then drain with wrap.
        mem_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            store(32'(4 * i), 4'hF, 32'hA0A0A0A0 + 32'(i));
            chk("t3_no_stall", 32'(stall_store), 32'd0);
            step();
        end
        chk("t3_full", 32'(stall_store), 32'd1);
        store(32'h10, 4'hF, 32'hA0A0A0A4);
        chk("t3_head_held", mem_addr, 32'h0);
        step();
        chk("t3_still_full", 32'(stall_store), 32'd1);
        mem_ready = 1'b1;
        #1;
        chk("t3_drain0", mem_data_wr, 32'hA0A0A0A0);
        chk("t3_stall_with_drain", 32'(stall_store), 32'd1);
        step();
        chk("t3_accept", 32'(stall_store), 32'd0);
        chk("t3_drain1", mem_addr, 32'h4);
        step(); idle();
        chk("t3_drain2", mem_addr, 32'h8);
        step();
        chk("t3_drain3", mem_addr, 32'hC);
        step();
        chk("t3_drain4_addr", mem_addr, 32'h10);
        chk("t3_drain4_data", mem_data_wr, 32'hA0A0A0A4);
        step();
        chk("t3_empty", 32'(sb_empty), 32'd1);

        // Youngest matching entry wins the forwarding.
        mem_ready = 1'b0;
        store(32'h200, 4'hF, 32'h11111111);
        step();
        store(32'h200, 4'h3, 32'h00002222);
        step();
        cs = 1'b1; wr = 1'b0; addr = 32'h200; mask = 4'hF; mem_data_rd = 32'hFFFFFFFF;
        #1;
        chk("t4_youngest", data_rd, 32'h11112222);
        idle();
        mem_ready = 1'b1;
        step(); step(); step();
        chk("t4_empty", 32'(sb_empty), 32'd1);

        // Coalescing (or not) of two partial stores to the same word.
        mem_ready = 1'b0;
        store(32'h20, 4'b0001, 32'h00000011);
        step();
        store(32'h20, 4'b0100, 32'h00330000);
        step(); idle();
        mem_ready = 1'b1;
        #1;
`ifdef SB_COALESCE_EN
        chk("t5_merge_mask", 32'(mem_mask), 32'h5);
        chk("t5_merge_data", mem_data_wr, 32'h00330011);
        step();
        chk("t5_merge_single", 32'(sb_empty), 32'd1);
`else
        chk("t5_first_mask", 32'(mem_mask), 32'h1);
        chk("t5_first_data", mem_data_wr, 32'h00000011);
        step();
        chk("t5_second_mask", 32'(mem_mask), 32'h4);
        chk("t5_second_data", mem_data_wr, 32'h00330000);
        step();
        chk("t5_empty", 32'(sb_empty), 32'd1);
`endif

        // Asynchronous reset mid-drain discards pending stores.
        mem_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            store(32'h40 + 32'(4 * i), 4'hF, 32'hC0C0C0C0 + 32'(i));
            step();
        end
        idle();
        chk("t6_draining", 32'(mem_cs), 32'd1);
        mem_data_rd = 32'h5A5A5A5A;
        #2 rst = 1'b1;
        #1;
        chk("t6_rst_memcs", 32'(mem_cs), 32'd0);
        chk("t6_rst_empty", 32'(sb_empty), 32'd1);
        chk("t6_rst_stall", 32'(stall_store), 32'd0);
        mem_ready = 1'b1;
        step();
        rst = 1'b0;
        step();
        chk("t6_no_write", 32'(mem_cs), 32'd0);
        addr = 32'h40;
        #1;
        chk("t6_no_fwd", data_rd, 32'h5A5A5A5A);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
